// File: rtl/johnson_gray_counter.sv
// johnson_gray_counter: N-bit Johnson counter with a 2N-state cycle, up/down
// stepping, synchronous load, and binary-index / Gray views of the state.
// REG_OUT=1 adds one aligned output register stage on every output.
// Optional macro JOHNSON_GRAY_ILLEGAL_CHECK_EN adds illegal-state detection
// with recovery to state 0, reported as a one-cycle pulse on err.
module johnson_gray_counter #(
  parameter int  N       = 4,
  parameter int  REG_OUT = 0,
  localparam int GW      = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [GW-1:0] load_idx,
  output logic [N-1:0]  j,
  output logic [GW-1:0] g,
  output logic [GW-1:0] idx,
  output logic          wrap,
  output logic          load_err,
  output logic          err
);

  // Index of a Johnson code: popcount while the MSB is clear, 2N - popcount once set.
  function automatic logic [GW-1:0] index_of(input logic [N-1:0] s);
    int pc;
    pc = 0;
    for (int b = 0; b < N; b++) pc += int'(s[b]);
    if (s[N-1]) index_of = GW'(2 * N - pc);
    else        index_of = GW'(pc);
  endfunction

  // Johnson code of an index: ones fill from the LSB, then zeros fill from the LSB.
  function automatic logic [N-1:0] johnson_of(input logic [GW-1:0] i);
    int ii;
    ii = int'(i);
    johnson_of = '0;
    for (int b = 0; b < N; b++)
      johnson_of[b] = (ii <= N) ? (b < ii) : (b >= ii - N);
  endfunction

  function automatic logic [GW-1:0] gray_of(input logic [GW-1:0] i);
    gray_of = i ^ (i >> 1);
  endfunction

`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
  // A legal Johnson code has at most one boundary between adjacent bits.
  function automatic logic is_legal(input logic [N-1:0] s);
    int t;
    t = 0;
    for (int k = 0; k < N - 1; k++) t += int'(s[k] != s[k+1]);
    is_legal = (t <= 1);
  endfunction
`endif

  logic [N-1:0]  state_p0, next_state;
  logic [GW-1:0] cur_idx, cur_gray;
  logic          in_range;
  logic          wrap_nxt, lerr_nxt;
  logic          wrap_p0, lerr_p0, err_p0;

  assign cur_idx  = index_of(state_p0);
  assign cur_gray = gray_of(cur_idx);
  assign in_range = (int'(load_idx) < 2 * N);

`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
  logic illegal, err_nxt;
  assign illegal = !is_legal(state_p0);
`endif

  // Next state and the pulses that accompany it; load beats en, recovery beats both.
  always_comb begin
    next_state = state_p0;
    wrap_nxt   = 1'b0;
    lerr_nxt   = 1'b0;
`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
    err_nxt    = 1'b0;
`endif
    if (load) begin
      if (in_range) next_state = johnson_of(load_idx);
      else          lerr_nxt   = 1'b1;
    end else if (en) begin
      if (dir) begin
        next_state = {state_p0[N-2:0], ~state_p0[N-1]};
        wrap_nxt   = (cur_idx == GW'(2 * N - 1));
      end else begin
        next_state = {~state_p0[0], state_p0[N-1:1]};
        wrap_nxt   = (cur_idx == '0);
      end
    end
`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
    if (illegal) begin
      next_state = '0;
      wrap_nxt   = 1'b0;
      err_nxt    = 1'b1;
    end
`endif
  end

  // Stage p0: counting state plus pulses aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= '0;
      wrap_p0  <= 1'b0;
      lerr_p0  <= 1'b0;
    end else begin
      state_p0 <= next_state;
      wrap_p0  <= wrap_nxt;
      lerr_p0  <= lerr_nxt;
    end
  end

`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
  // Stage p0: illegal-state pulse, presented alongside the recovered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_p0 <= 1'b0;
    else     err_p0 <= err_nxt;
  end
`else
  assign err_p0 = 1'b0;
`endif

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [N-1:0]  j_p1;
      logic [GW-1:0] g_p1, idx_p1;
      logic          wrap_p1, lerr_p1, err_p1;

      // Stage p1: every output delayed together so they stay mutually coherent.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          j_p1    <= '0;
          g_p1    <= '0;
          idx_p1  <= '0;
          wrap_p1 <= 1'b0;
          lerr_p1 <= 1'b0;
          err_p1  <= 1'b0;
        end else begin
          j_p1    <= state_p0;
          g_p1    <= cur_gray;
          idx_p1  <= cur_idx;
          wrap_p1 <= wrap_p0;
          lerr_p1 <= lerr_p0;
          err_p1  <= err_p0;
        end
      end

      assign j        = j_p1;
      assign g        = g_p1;
      assign idx      = idx_p1;
      assign wrap     = wrap_p1;
      assign load_err = lerr_p1;
      assign err      = err_p1;
    end else begin : g_comb_out
      assign j        = state_p0;
      assign g        = cur_gray;
      assign idx      = cur_idx;
      assign wrap     = wrap_p0;
      assign load_err = lerr_p0;
      assign err      = err_p0;
    end
  endgenerate

endmodule

// File: tb/tb_johnson_gray_counter.sv
// Bench for johnson_gray_counter: N=4/REG_OUT=0, N=3/REG_OUT=0, N=5/REG_OUT=1.
module tb_johnson_gray_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en4, dir4, load4, wrap4, lerr4, err4;
  logic [2:0] lidx4, g4, idx4;
  logic [3:0] j4;

  logic       en3, dir3, load3, wrap3, lerr3, err3;
  logic [2:0] lidx3, g3, idx3, j3;

  logic       en5, dir5, load5, wrap5, lerr5, err5;
  logic [3:0] lidx5, g5, idx5;
  logic [4:0] j5;

  johnson_gray_counter #(.N(4), .REG_OUT(0)) u4 (
    .clk(clk), .rst(rst), .en(en4), .dir(dir4), .load(load4), .load_idx(lidx4),
    .j(j4), .g(g4), .idx(idx4), .wrap(wrap4), .load_err(lerr4), .err(err4));

  johnson_gray_counter #(.N(3), .REG_OUT(0)) u3 (
    .clk(clk), .rst(rst), .en(en3), .dir(dir3), .load(load3), .load_idx(lidx3),
    .j(j3), .g(g3), .idx(idx3), .wrap(wrap3), .load_err(lerr3), .err(err3));

  johnson_gray_counter #(.N(5), .REG_OUT(1)) u5 (
    .clk(clk), .rst(rst), .en(en5), .dir(dir5), .load(load5), .load_idx(lidx5),
    .j(j5), .g(g5), .idx(idx5), .wrap(wrap5), .load_err(lerr5), .err(err5));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the counter as an index on a ring of 2N positions.
  function automatic int jcode(input int n, input int i);
    int m;
    m = (1 << n) - 1;
    if (i <= n) return (1 << i) - 1;
    return m & (m << (i - n));
  endfunction

  function automatic int gray(input int i);
    return i ^ (i >> 1);
  endfunction

  task automatic mstep(input int n, input int cur, input bit e, input bit d,
                       input bit l, input int li, output int nxt, output bit w,
                       output bit le);
    nxt = cur; w = 1'b0; le = 1'b0;
    if (l) begin
      if (li < 2 * n) nxt = li;
      else            le  = 1'b1;
    end else if (e) begin
      if (d) begin nxt = (cur + 1) % (2 * n);         w = (cur == 2 * n - 1); end
      else   begin nxt = (cur + 2 * n - 1) % (2 * n); w = (cur == 0);         end
    end
  endtask

  int cur4, cur5;
  bit cw5, cle5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en4 = 0; dir4 = 0; load4 = 0; lidx4 = '0;
    en3 = 0; dir3 = 0; load3 = 0; lidx3 = '0;
    en5 = 0; dir5 = 0; load5 = 0; lidx5 = '0;
  endtask

  // One clock: advance both models, check u4 (same-edge) and u5 (one stage late).
  task automatic cycle();
    int n4, n5;
    bit w4, le4, w5, le5;
    mstep(4, cur4, en4, dir4, load4, int'(lidx4), n4, w4, le4);
    mstep(5, cur5, en5, dir5, load5, int'(lidx5), n5, w5, le5);
    tick();
    chk("u4_j",    int'(j4),    jcode(4, n4));
    chk("u4_idx",  int'(idx4),  n4);
    chk("u4_g",    int'(g4),    gray(n4));
    chk("u4_wrap", int'(wrap4), int'(w4));
    chk("u4_lerr", int'(lerr4), int'(le4));
    chk("u4_err",  int'(err4),  0);
    chk("u5_j",    int'(j5),    jcode(5, cur5));
    chk("u5_idx",  int'(idx5),  cur5);
    chk("u5_g",    int'(g5),    gray(cur5));
    chk("u5_wrap", int'(wrap5), int'(cw5));
    chk("u5_lerr", int'(lerr5), int'(cle5));
    chk("u5_err",  int'(err5),  0);
    cur4 = n4; cur5 = n5; cw5 = w5; cle5 = le5;
    idle();
  endtask

  typedef struct {
    bit e, d, l;
    int li, j, g, idx;
    bit w, le;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit e, input bit d, input bit l, input int li,
                      input int j, input int g, input int ix, input bit w, input bit le);
    vec_t v;
    v.e = e; v.d = d; v.l = l; v.li = li; v.j = j; v.g = g; v.idx = ix; v.w = w; v.le = le;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    #7;
    chk("rst_u4_j", int'(j4), 0);     chk("rst_u4_idx", int'(idx4), 0);
    chk("rst_u4_g", int'(g4), 0);     chk("rst_u4_wrap", int'(wrap4), 0);
    chk("rst_u4_lerr", int'(lerr4), 0); chk("rst_u4_err", int'(err4), 0);
    chk("rst_u3_j", int'(j3), 0);     chk("rst_u5_j", int'(j5), 0);
    chk("rst_u5_idx", int'(idx5), 0); chk("rst_u5_wrap", int'(wrap5), 0);
    #5 rst = 1'b0;
    cur4 = 0; cur5 = 0; cw5 = 0; cle5 = 0;
    cycle();

    // Directed N=4 vectors: up walk, down wrap, load, hold, load without wrap.
    addv(1,1,0,0, 4'b0001, 3'b001, 1, 0, 0);
    addv(1,1,0,0, 4'b0011, 3'b011, 2, 0, 0);
    addv(1,1,0,0, 4'b0111, 3'b010, 3, 0, 0);
    addv(1,1,0,0, 4'b1111, 3'b110, 4, 0, 0);
    addv(1,1,0,0, 4'b1110, 3'b111, 5, 0, 0);
    addv(1,1,0,0, 4'b1100, 3'b101, 6, 0, 0);
    addv(1,1,0,0, 4'b1000, 3'b100, 7, 0, 0);
    addv(1,1,0,0, 4'b0000, 3'b000, 0, 1, 0);
    addv(1,1,0,0, 4'b0001, 3'b001, 1, 0, 0);
    addv(1,0,0,0, 4'b0000, 3'b000, 0, 0, 0);
    addv(1,0,0,0, 4'b1000, 3'b100, 7, 1, 0);
    addv(1,0,0,0, 4'b1100, 3'b101, 6, 0, 0);
    addv(1,0,1,5, 4'b1110, 3'b111, 5, 0, 0);
    addv(0,0,0,0, 4'b1110, 3'b111, 5, 0, 0);
    addv(1,1,1,7, 4'b1000, 3'b100, 7, 0, 0);
    addv(1,1,1,0, 4'b0000, 3'b000, 0, 0, 0);
    addv(1,1,0,0, 4'b0001, 3'b001, 1, 0, 0);
    addv(1,0,0,0, 4'b0000, 3'b000, 0, 0, 0);
    addv(1,0,0,0, 4'b1000, 3'b100, 7, 1, 0);
    addv(1,1,0,0, 4'b0000, 3'b000, 0, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      en4 = tbl[i].e; dir4 = tbl[i].d; load4 = tbl[i].l; lidx4 = 3'(tbl[i].li);
      cycle();
      chk("tbl_j",    int'(j4),    tbl[i].j);
      chk("tbl_g",    int'(g4),    tbl[i].g);
      chk("tbl_idx",  int'(idx4),  tbl[i].idx);
      chk("tbl_wrap", int'(wrap4), int'(tbl[i].w));
      chk("tbl_lerr", int'(lerr4), int'(tbl[i].le));
    end

    // N=3: out-of-range load holds and pulses load_err; wrap on a 6-state ring.
    load3 = 1; lidx3 = 3'd7; cycle();
    chk("u3_oor_j", int'(j3), 0); chk("u3_oor_lerr", int'(lerr3), 1); chk("u3_oor_wrap", int'(wrap3), 0);
    cycle();
    chk("u3_lerr_clear", int'(lerr3), 0);
    load3 = 1; lidx3 = 3'd5; cycle();
    chk("u3_ld5_j", int'(j3), 3'b100); chk("u3_ld5_idx", int'(idx3), 5); chk("u3_ld5_g", int'(g3), 3'b111);
    en3 = 1; dir3 = 1; cycle();
    chk("u3_upwrap_j", int'(j3), 0); chk("u3_upwrap_w", int'(wrap3), 1); chk("u3_upwrap_g", int'(g3), 0);
    load3 = 1; lidx3 = 3'd6; en3 = 1; dir3 = 1; cycle();
    chk("u3_oor6_j", int'(j3), 0); chk("u3_oor6_lerr", int'(lerr3), 1); chk("u3_oor6_wrap", int'(wrap3), 0);
    en3 = 1; dir3 = 0; cycle();
    chk("u3_dnwrap_j", int'(j3), 3'b100); chk("u3_dnwrap_idx", int'(idx3), 5);
    chk("u3_dnwrap_w", int'(wrap3), 1); chk("u3_dnwrap_lerr", int'(lerr3), 0);
    cycle();
    chk("u3_wrap_clear", int'(wrap3), 0);

    // N=5 registered outputs: 12 up steps, outputs trail state by one cycle.
    for (int k = 1; k <= 12; k++) begin
      en5 = 1; dir5 = 1;
      cycle();
      if (k == 10) chk("u5_g_at_idx9", int'(g5), 4'b1101);
      if (k == 11) chk("u5_wrap_with_idx0", int'(wrap5 && idx5 == 4'd0), 1);
    end

    // Randomised traffic on both model-checked instances.
    for (int i = 0; i < 300; i++) begin
      en4 = ($urandom_range(0, 3) != 0); dir4 = 1'($urandom_range(0, 1));
      load4 = ($urandom_range(0, 7) == 0); lidx4 = 3'($urandom_range(0, 7));
      en5 = ($urandom_range(0, 3) != 0); dir5 = 1'($urandom_range(0, 1));
      load5 = ($urandom_range(0, 5) == 0); lidx5 = 4'($urandom_range(0, 15));
      cycle();
    end

    // Asynchronous reset mid-count at idx 6, then resume with no wrap.
    load4 = 1; lidx4 = 3'd6; load5 = 1; lidx5 = 4'd6;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("amid_u4_j", int'(j4), 0); chk("amid_u4_idx", int'(idx4), 0);
    chk("amid_u4_g", int'(g4), 0); chk("amid_u4_wrap", int'(wrap4), 0);
    chk("amid_u5_j", int'(j5), 0); chk("amid_u5_idx", int'(idx5), 0);
    en4 = 1; dir4 = 1;
    tick();
    chk("rst_hold_u4_j", int'(j4), 0); chk("rst_hold_u5_idx", int'(idx5), 0);
    #2 rst = 1'b0;
    cur4 = 0; cur5 = 0; cw5 = 0; cle5 = 0;
    idle();
    en4 = 1; dir4 = 0; en5 = 1; dir5 = 0;
    cycle();
    en4 = 1; dir4 = 1; en5 = 1; dir5 = 1;
    cycle();
    cycle();

`ifdef JOHNSON_GRAY_ILLEGAL_CHECK_EN
    force u4.state_p0 = 4'b0101;
    #1;
    release u4.state_p0;
    load4 = 1; lidx4 = 3'd3; en4 = 1;
    tick();
    chk("ill_j", int'(j4), 0); chk("ill_err", int'(err4), 1); chk("ill_wrap", int'(wrap4), 0);
    idle();
    tick();
    chk("ill_err_clear", int'(err4), 0); chk("ill_hold_j", int'(j4), 0);
    cur4 = 0; cw5 = 0; cle5 = 0;
    cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_gray_counter.md
Name: johnson_gray_counter

Overview:
- Parametrised N-bit Johnson counter with a 2N-state cycle, up/down count, synchronous load and integrated Johnson-to-Gray conversion.
- The Gray code is the Gray encoding of the state index.
- Next generation of the fixed 4-bit combinational Johnson-to-Gray converter: generalised in width, and it now owns the counting state.
- Used by position and phase sequencers that need a glitch-free one-hot-transition count plus a compact Gray/binary view.

Parameters:
- N, 4: Johnson register width; cycle length is 2N. Legal range 2..16.
- REG_OUT, 0: 0 = g/idx combinational from state; 1 = j/g/idx/wrap all delayed one extra register stage, mutually aligned.
- Derived localparam GW = clog2(2N), which is the Gray and index width. With N=4, GW=3.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance one step when high
- dir  in  1  1 = up, 0 = down
- load  in  1  synchronous load of load_idx; has priority over en
- load_idx  in  GW  target index, 0..2N-1
- j  out  N  Johnson state
- g  out  GW  Gray code of idx, computed as idx ^ (idx >> 1)
- idx  out  GW  binary state index 0..2N-1
- wrap  out  1  one-cycle pulse on cycle wrap
- load_err  out  1  one-cycle pulse when load_idx is out of range
- err  out  1  illegal-state pulse; present only with the optional feature, otherwise tied to 0

Behaviour:
- Reset (async, immediate): state = 0, j = 0, g = 0, idx = 0, wrap = 0, load_err = 0, err = 0. With REG_OUT=1 the output pipeline register also clears.
- Up step: next = {j[N-2:0], ~j[N-1]}.
  - N=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Down step: next = {~j[0], j[N-1:1]}, which is the exact reverse of the up sequence.
- Index rule:
  - idx = popcount(j) when j[N-1] = 0.
  - idx = 2N - popcount(j) when j[N-1] = 1.
  - For N=4 this matches the legacy table, e.g. 0111 gives g=010 and 1110 gives g=111.
- Load (load = 1):
  - If load_idx < 2N: state becomes the Johnson code of load_idx at the next edge; en and dir are ignored.
  - If load_idx >= 2N: state is held and load_err pulses for 1 cycle.
  - Load never asserts wrap.
- Hold: load = 0 and en = 0 holds state.
- wrap:
  - Asserted for the single cycle in which the presented state is the result of a counting step from idx 2N-1 to idx 0 (up), or from idx 0 to idx 2N-1 (down).
  - Deasserted otherwise.
- Gray adjacency:
  - Guaranteed for every step when 2N is a power of two.
  - Otherwise guaranteed for all steps except the wrap step. This is documented, not an error.
- Latency (input edge to outputs):
  - REG_OUT=0: j/idx/g update at the same edge as the state.
  - REG_OUT=1: one extra cycle. wrap, load_err and err are delayed by the same stage so all outputs stay coherent.
- Direction change: dir may toggle on any cycle; the step uses the dir value sampled at that edge.
- Reset mid-operation: a rst pulse of any length, in any phase, returns to idx 0 with no wrap pulse.

Optional Feature:
- Macro: JOHNSON_GRAY_ILLEGAL_CHECK_EN.
- Legality rule: a state is legal iff the count of k in 0..N-2 with j[k] != j[k+1] is <= 1.
- Defined:
  - An illegal state (SEU or forced) is detected combinationally.
  - At the next edge the state is forced to 0, overriding load and en.
  - err pulses 1 cycle with the corrected output, and wrap is not asserted.
  - load_err is still asserted if load was also high with load_idx out of range.
- Undefined:
  - No checker logic; err is a constant 0.
  - An illegal state propagates through the shift logic per the step equations (no recovery guarantee). idx/g for illegal states are don't-care.

Test Plan:
- N=4, REG_OUT=0, rst then en=1, dir=1 for 9 cycles -> j walks 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; g: 001, 011, 010, 110, 111, 101, 100, 000, 001; wrap=1 only on the 0000 cycle.
- From idx 0 with en=1, dir=0 -> j = 1000, idx = 7, g = 100, wrap = 1; the next cycle gives j = 1100, idx = 6, wrap = 0.
- load=1, load_idx=5, en=1 -> next cycle j=1110, idx=5, g=111, wrap=0. Then load_idx=7 with N=3 (2N=6, GW=3) -> state held, load_err=1 for one cycle.
- N=5, REG_OUT=1, count up 10 steps -> outputs lag the state by one cycle; idx goes 0..9 then 0, with wrap aligned to the idx=0 output; g at idx 9 is 01101.
- Assert rst mid-count at idx 6 -> outputs are 0 immediately (asynchronously) before the next clk edge; after release, counting resumes from idx 0 with no wrap pulse.
- With JOHNSON_GRAY_ILLEGAL_CHECK_EN, N=4: force internal state to 0101 for one edge -> next edge j=0000, err=1 for one cycle. Without the macro -> err stays 0.
